fir_mac_seq: RTL and testbench

- Time-multiplexed multiply-accumulate stage directly downstream of the FIR tap delay line.
- Captures the N-tap sample vector on each valid strobe and multiplies it against a writable coefficient bank, one tap per cycle.
- Rounds and scales the sum, then emits one 16-bit filtered sample per accepted input.

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_round_sat.sv | 35 +++
 rtl/fir_mac_seq.sv | 133 +++++++++++++
 tb/tb_fir_mac_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, sample/coefficient types and MAC state encoding
package fir_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } mac_state_t;

endpackage

// File: rtl/fir_round_sat.sv
// rtl/fir_round_sat.sv - round-half-up shift of the accumulator to 16 bits
// FIR_MAC_SAT_EN selects saturation to [-32768, 32767]; otherwise the result wraps.
module fir_round_sat #(
  parameter int ACC_W   = 35,
  parameter int FRAC_SH = 15
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic [15:0]             o_data
);

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_SH - 1);

`ifdef FIR_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MIN_S = ACC_W'(-32768);

  logic signed [ACC_W-1:0] w_r;

  assign w_r = (i_acc + HALF) >>> FRAC_SH;

  always_comb begin
    if (w_r > MAX_S) begin
      o_data = 16'h7fff;
    end else if (w_r < MIN_S) begin
      o_data = 16'h8000;
    end else begin
      o_data = w_r[15:0];
    end
  end
`else
  // Truncating the shifted sum keeps the low 16 bits: plain two's-complement wrap.
  assign o_data = 16'((i_acc + HALF) >>> FRAC_SH);
`endif

endmodule

// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - time-multiplexed N-tap MAC, one tap per cycle, one sample out per vector
// Output saturation vs wrap is chosen by FIR_MAC_SAT_EN inside fir_round_sat.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int N       = 8,
  parameter int FRAC_SH = 15,
  parameter int ACC_W   = 32 + $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W*N-1:0]   taps_in,
  output logic                  in_ready,
  input  logic                  coef_we,
  input  logic [$clog2(N)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]     coef_data,
  output logic                  out_valid,
  output logic [15:0]           data_out,
  output logic                  busy,
  output logic                  overrun
);

  localparam int IDX_W = $clog2(N);

  mac_state_t              r_state;
  mac_state_t              w_next_state;
  logic [IDX_W-1:0]        r_idx;
  logic signed [ACC_W-1:0] r_acc;
  sample_t                 r_snap [N];
  coef_t                   r_coef [N];
  logic                    r_out_valid;
  logic                    r_overrun;
  logic [15:0]             r_data_out;

  logic                    w_last;
  logic                    w_coef_wr;
  logic signed [31:0]      w_snap_x;
  logic signed [31:0]      w_coef_x;
  logic signed [31:0]      w_prod;
  logic [15:0]             w_rounded;

  assign w_last    = (r_idx == IDX_W'(N - 1));
  // The bank only changes in IDLE so an operation always sees one consistent set.
  assign w_coef_wr = (r_state == IDLE) && coef_we && (32'(coef_addr) < 32'(N));
  assign w_snap_x  = 32'(r_snap[r_idx]);
  assign w_coef_x  = 32'(r_coef[r_idx]);
  assign w_prod    = w_snap_x * w_coef_x;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = ACCUM;
      ACCUM:   if (w_last) w_next_state = OUT;
      OUT:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == IDLE);
    busy     = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_data_out  <= '0;
      for (int i = 0; i < N; i++) begin
        r_snap[i] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      if (in_valid && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N; i++) begin
              r_snap[i] <= taps_in[i*DATA_W +: DATA_W];
            end
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        ACCUM: begin
          r_acc <= r_acc + {{(ACC_W-32){w_prod[31]}}, w_prod};
          r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end
        OUT: begin
          r_data_out  <= w_rounded;
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        r_coef[i] <= '0;
      end
    end else if (w_coef_wr) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  fir_round_sat #(
    .ACC_W   (ACC_W),
    .FRAC_SH (FRAC_SH)
  ) u_round_sat (
    .i_acc  (r_acc),
    .o_data (w_rounded)
  );

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb/tb_fir_mac_seq.sv - randomized self-checking bench for fir_mac_seq against an integer model
module tb_fir_mac_seq;

  localparam int N  = 8;
  localparam int AW = $clog2(N);

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [16*N-1:0] taps_in;
  logic            in_ready;
  logic            coef_we;
  logic [AW-1:0]   coef_addr;
  logic [15:0]     coef_data;
  logic            out_valid;
  logic [15:0]     data_out;
  logic            busy;
  logic            overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int m_coef [N];
  int v_taps [N];

  fir_mac_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .taps_in   (taps_in),
    .in_ready  (in_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .data_out  (data_out),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_out();
    longint acc;
    longint r;
    acc = 0;
    for (int i = 0; i < N; i++) acc += longint'(v_taps[i]) * longint'(m_coef[i]);
    r = (acc + 64'sd16384) >>> 15;
`ifdef FIR_MAC_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  function automatic int rand_s16();
    logic [15:0] u;
    u = 16'($urandom);
    return int'($signed(u));
  endfunction

  task automatic write_coef(input int addr, input int val);
    coef_addr = AW'(addr);
    coef_data = 16'(val);
    coef_we   = 1'b1;
    @(negedge clk);
    coef_we   = 1'b0;
    m_coef[addr] = val;
  endtask

  task automatic pack_taps();
    for (int i = 0; i < N; i++) taps_in[i*16 +: 16] = 16'(v_taps[i]);
  endtask

  task automatic run_vector(output logic [15:0] got, output int lat, output int nbusy);
    pack_taps();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    nbusy = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    got = data_out;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0; taps_in = '0;
    for (int i = 0; i < N; i++) m_coef[i] = 0;
    repeat (3) @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 0000", data_out); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_impulse();
    logic [15:0] got; int lat; int nb;
    write_coef(0, 32'h7fff);
    for (int i = 0; i < N; i++) v_taps[i] = 0;
    v_taps[0] = 32'h7fff;
    run_vector(got, lat, nb);
    n_tests++; if (lat !== N + 1) begin n_fail++; $display("FAIL impulse_latency: got %0d expected %0d", lat, N + 1); end
    n_tests++; if (got !== 16'h7ffe) begin n_fail++; $display("FAIL impulse_data: got %h expected 7ffe", got); end
    n_tests++; if (nb !== N + 1) begin n_fail++; $display("FAIL impulse_busy_cycles: got %0d expected %0d", nb, N + 1); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL impulse_pulse_width: got %b expected 0", out_valid); end
    n_tests++; if (data_out !== 16'h7ffe) begin n_fail++; $display("FAIL impulse_hold: got %h expected 7ffe", data_out); end
  endtask

  task automatic test_overflow();
    logic [15:0] got; logic [15:0] exp; int lat; int nb;
    for (int i = 0; i < N; i++) write_coef(i, 32'h4000);
    for (int i = 0; i < N; i++) v_taps[i] = 32'h2000;
`ifdef FIR_MAC_SAT_EN
    exp = 16'h7fff;
`else
    exp = 16'h8000;
`endif
    run_vector(got, lat, nb);
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL overflow_data: got %h expected %h", got, exp); end
  endtask

  task automatic test_neg_round();
    logic [15:0] got; int lat; int nb;
    write_coef(0, 32'h4000);
    for (int i = 1; i < N; i++) write_coef(i, 0);
    for (int i = 0; i < N; i++) v_taps[i] = 0;
    v_taps[0] = -1;
    run_vector(got, lat, nb);
    n_tests++; if (got !== 16'h0000) begin n_fail++; $display("FAIL neground_m1: got %h expected 0000", got); end
    v_taps[0] = -3;
    run_vector(got, lat, nb);
    n_tests++; if (got !== 16'hffff) begin n_fail++; $display("FAIL neground_m3: got %h expected ffff", got); end
  endtask

  task automatic test_random();
    logic [15:0] got; logic [15:0] exp; int lat; int nb;
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < int'($urandom_range(1, 3)); j++)
        write_coef(int'($urandom_range(0, N - 1)), rand_s16());
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0:       v_taps[i] = 32767;
          1:       v_taps[i] = -32768;
          default: v_taps[i] = rand_s16();
        endcase
      end
      exp = model_out();
      run_vector(got, lat, nb);
      n_tests++; if (got !== exp) begin n_fail++; $display("FAIL random_data[%0d]: got %h expected %h", k, got, exp); end
      n_tests++; if (lat !== N + 1) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d expected %0d", k, lat, N + 1); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got; logic [15:0] exp; int lat; int nb;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) v_taps[i] = rand_s16();
      exp = model_out();
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, in_ready); end
      run_vector(got, lat, nb);
      n_tests++; if (got !== exp) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, got, exp); end
      n_tests++; if (lat !== N + 1) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", k, lat, N + 1); end
    end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_overrun();
    logic [15:0] exp; logic [15:0] seen; int pulses; logic ready_low;
    @(negedge clk);
    for (int i = 0; i < N; i++) v_taps[i] = rand_s16();
    exp = model_out();
    pack_taps();
    in_valid = 1'b1;
    ready_low = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) taps_in[i*16 +: 16] = 16'($urandom);
      if (in_ready !== 1'b0) ready_low = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    pulses = 0;
    seen = 16'hxxxx;
    for (int c = 0; c < N + 8; c++) begin
      if (out_valid === 1'b1) begin pulses++; seen = data_out; end
      else if (busy === 1'b1 && in_ready !== 1'b0) ready_low = 1'b0;
      @(negedge clk);
    end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d expected 1", pulses); end
    n_tests++; if (seen !== exp) begin n_fail++; $display("FAIL overrun_data: got %h expected %h", seen, exp); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b expected 1", overrun); end
    n_tests++; if (ready_low !== 1'b1) begin n_fail++; $display("FAIL overrun_ready_low: got %b expected 1", ready_low); end
  endtask

  task automatic test_coef_lock();
    logic [15:0] got; logic [15:0] exp; int lat; int nb;
    write_coef(0, 32'h1234);
    for (int i = 0; i < N; i++) v_taps[i] = rand_s16();
    exp = model_out();
    pack_taps();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    coef_addr = '0;
    coef_data = 16'h5555;
    coef_we   = 1'b1;
    @(negedge clk);
    coef_we = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_tests++; if (data_out !== exp) begin n_fail++; $display("FAIL lock_during_op: got %h expected %h", data_out, exp); end
    for (int i = 0; i < N; i++) v_taps[i] = rand_s16();
    exp = model_out();
    run_vector(got, lat, nb);
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL lock_next_vector: got %h expected %h", got, exp); end
    write_coef(0, 32'h5555);
    exp = model_out();
    run_vector(got, lat, nb);
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL lock_idle_rewrite: got %h expected %h", got, exp); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got; int lat; int nb; int pulses;
    for (int i = 0; i < N; i++) v_taps[i] = rand_s16();
    pack_taps();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL midrst_data_out: got %h expected 0000", data_out); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun: got %b expected 0", overrun); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) m_coef[i] = 0;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    pulses = 0;
    for (int c = 0; c < N + 4; c++) begin
      if (out_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_pulse: got %0d expected 0", pulses); end
    v_taps[0] = 32'h7fff;
    run_vector(got, lat, nb);
    n_tests++; if (got !== model_out()) begin n_fail++; $display("FAIL midrst_coef_cleared: got %h expected %h", got, model_out()); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_overflow();
    test_neg_round();
    test_random();
    test_back_to_back();
    test_overrun();
    test_coef_lock();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
